sd_emmc_cmd_serial_host: RTL and testbench

//  Command-line PHY stage directly downstream of the eMMC command-layer FSM.

---
 rtl/sd_emmc_cmd_serial_host.sv | 245 ++++++++++++++++++++++++
 tb/tb_sd_emmc_cmd_serial_host.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_emmc_cmd_serial_host.sv
// eMMC command-line PHY: serialises a 48-bit command frame with CRC7 and
// captures the 48- or 136-bit response, checking its CRC7 and command index.
module sd_emmc_cmd_serial_host #(
  parameter int NCC     = 8,
  parameter int NCR_MIN = 2
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         go_idle_i,
  input  logic [1:0]   setting_i,
  input  logic [39:0]  cmd_i,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic [119:0] response_o,
  output logic         crc_ok_o,
  output logic         index_ok_o,
  output logic         finish_o
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ,
    NCC_WAIT,
    FINISH
  } state_t;

  localparam logic [7:0] NCC_LAST    = 8'(NCC - 1);
  localparam logic [7:0] NCR_MIN_CNT = 8'(NCR_MIN);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [39:0]    tx_sh_q, tx_sh_d;
  logic [5:0]     cmd_idx_q, cmd_idx_d;
  logic           long_q, long_d;
  logic           expect_q, expect_d;
  logic [6:0]     crc_q, crc_d;
  logic [5:0]     rx_idx_q, rx_idx_d;
  logic [6:0]     rx_crc_q, rx_crc_d;
  logic           out_q, out_d;
  logic           oe_q, oe_d;
  logic [119:0]   resp_q, resp_d;
  logic           crc_ok_q, crc_ok_d;
  logic           idx_ok_q, idx_ok_d;
  logic           fin_q, fin_d;
  logic [7:0]     rx_crc_first;
  logic [7:0]     rx_last;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign cmd_out_o  = out_q;
  assign cmd_oe_o   = oe_q;
  assign response_o = resp_q;
  assign crc_ok_o   = crc_ok_q;
  assign index_ok_o = idx_ok_q;
  assign finish_o   = fin_q;

  // Receive bit positions, counted from the start bit (count 0).
  assign rx_crc_first = long_q ? 8'd128 : 8'd40;
  assign rx_last      = long_q ? 8'd135 : 8'd47;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      tx_sh_q   <= 40'd0;
      cmd_idx_q <= 6'd0;
      long_q    <= 1'b0;
      expect_q  <= 1'b0;
      crc_q     <= 7'd0;
      rx_idx_q  <= 6'd0;
      rx_crc_q  <= 7'd0;
      out_q     <= 1'b1;
      oe_q      <= 1'b1;
      resp_q    <= 120'd0;
      crc_ok_q  <= 1'b0;
      idx_ok_q  <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sh_q   <= tx_sh_d;
      cmd_idx_q <= cmd_idx_d;
      long_q    <= long_d;
      expect_q  <= expect_d;
      crc_q     <= crc_d;
      rx_idx_q  <= rx_idx_d;
      rx_crc_q  <= rx_crc_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      resp_q    <= resp_d;
      crc_ok_q  <= crc_ok_d;
      idx_ok_q  <= idx_ok_d;
      fin_q     <= fin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_sh_d   = tx_sh_q;
    cmd_idx_d = cmd_idx_q;
    long_d    = long_q;
    expect_d  = expect_q;
    crc_d     = crc_q;
    rx_idx_d  = rx_idx_q;
    rx_crc_d  = rx_crc_q;
    out_d     = out_q;
    oe_d      = oe_q;
    resp_d    = resp_q;
    crc_ok_d  = crc_ok_q;
    idx_ok_d  = idx_ok_q;
    fin_d     = 1'b0;

    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        oe_d  = 1'b1;
        cnt_d = 8'd0;
        if (start_i) begin
          // Bit 47 goes out on this edge, so it is already folded into the CRC.
          tx_sh_d   = {cmd_i[38:0], 1'b0};
          cmd_idx_d = cmd_i[37:32];
          long_d    = setting_i[1];
          expect_d  = setting_i[0];
          crc_d     = crc7_step(7'd0, cmd_i[39]);
          crc_ok_d  = 1'b0;
          idx_ok_d  = 1'b0;
          resp_d    = 120'd0;
          out_d     = cmd_i[39];
          cnt_d     = 8'd1;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q < 8'd40) begin
          out_d   = tx_sh_q[39];
          tx_sh_d = {tx_sh_q[38:0], 1'b0};
          crc_d   = crc7_step(crc_q, tx_sh_q[39]);
        end else if (cnt_q < 8'd47) begin
          out_d = crc_q[6];
          crc_d = {crc_q[5:0], 1'b0};
        end else if (cnt_q == 8'd47) begin
          out_d = 1'b1;
        end else begin
          out_d = 1'b1;
          cnt_d = 8'd0;
          if (expect_q) begin
            oe_d    = 1'b0;
            state_d = READ_WAIT;
          end else begin
            state_d = NCC_WAIT;
          end
        end
      end

      READ_WAIT: begin
        oe_d  = 1'b0;
        out_d = 1'b1;
        if (cnt_q < NCR_MIN_CNT) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!cmd_dat_i) begin
          state_d  = READ;
          cnt_d    = 8'd1;
          crc_d    = 7'd0;
          rx_idx_d = 6'd0;
          rx_crc_d = 7'd0;
        end
      end

      READ: begin
        cnt_d = cnt_q + 8'd1;
        // Long responses exclude the start, transmission and reserved bits from the CRC.
        if (long_q ? (cnt_q >= 8'd8 && cnt_q < 8'd128) : (cnt_q < 8'd40)) begin
          crc_d = crc7_step(crc_q, cmd_dat_i);
        end
        if (!long_q && cnt_q >= 8'd2 && cnt_q < 8'd8) begin
          rx_idx_d = {rx_idx_q[4:0], cmd_dat_i};
        end
        if (cnt_q >= 8'd8 && cnt_q < rx_crc_first) begin
          resp_d = {resp_q[118:0], cmd_dat_i};
        end
        if (cnt_q >= rx_crc_first && cnt_q < rx_last) begin
          rx_crc_d = {rx_crc_q[5:0], cmd_dat_i};
        end
        if (cnt_q == rx_last) begin
          crc_ok_d = (rx_crc_q == crc_q);
          idx_ok_d = long_q | (rx_idx_q == cmd_idx_q);
          if (!long_q) begin
            resp_d = {resp_q[31:0], 88'd0};
          end
          oe_d    = 1'b1;
          out_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = NCC_WAIT;
        end
      end

      NCC_WAIT: begin
        oe_d  = 1'b1;
        out_d = 1'b1;
        if (cnt_q == NCC_LAST) begin
          cnt_d   = 8'd0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      FINISH: begin
        fin_d   = 1'b1;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start request.
    if (go_idle_i) begin
      state_d  = IDLE;
      oe_d     = 1'b1;
      out_d    = 1'b1;
      cnt_d    = 8'd0;
      crc_d    = 7'd0;
      rx_idx_d = 6'd0;
      rx_crc_d = 7'd0;
      crc_ok_d = 1'b0;
      idx_ok_d = 1'b0;
      fin_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_emmc_cmd_serial_host.sv
// Self-checking bench for sd_emmc_cmd_serial_host: directed and random commands
// checked against a polynomial-division CRC7 model and frame builders.
module tb_sd_emmc_cmd_serial_host;

  localparam int NCC = 8;

  logic         sd_clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         go_idle_i;
  logic [1:0]   setting_i;
  logic [39:0]  cmd_i;
  logic         cmd_dat_i;
  logic         cmd_out_o;
  logic         cmd_oe_o;
  logic [119:0] response_o;
  logic         crc_ok_o;
  logic         index_ok_o;
  logic         finish_o;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int test_no   = 0;

  sd_emmc_cmd_serial_host #(.NCC(NCC), .NCR_MIN(2)) dut (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .start_i    (start_i),
    .go_idle_i  (go_idle_i),
    .setting_i  (setting_i),
    .cmd_i      (cmd_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .response_o (response_o),
    .crc_ok_o   (crc_ok_o),
    .index_ok_o (index_ok_o),
    .finish_o   (finish_o)
  );

  always #5 sd_clk = ~sd_clk;

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [119:0] data, input int nbits);
    logic [127:0] r;
    r = {8'd0, data} << 7;
    for (int i = nbits + 6; i >= 7; i--) begin
      if (r[i]) r = r ^ (128'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] tx_model(input logic [39:0] cmd);
    return {cmd, crc7_ref({80'd0, cmd}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] status,
                                               input logic flip);
    logic [39:0] body;
    logic [6:0]  c;
    body = {2'b00, idx, status};
    c    = crc7_ref({80'd0, body}, 40);
    if (flip) c[3] = ~c[3];
    return {88'd0, body, c, 1'b1};
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] cid, input logic flip);
    logic [6:0] c;
    c = crc7_ref(cid, 120);
    if (flip) c[0] = ~c[0];
    return {2'b00, 6'b111111, cid, c, 1'b1};
  endfunction

  task automatic check_output(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL t%0d_%s: observed %0h expected %0h", test_no, tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_oe"}, 136'(cmd_oe_o), 136'(1'b1));
    check_output({tag, "_out"}, 136'(cmd_out_o), 136'(1'b1));
    check_output({tag, "_resp"}, 136'(response_o), 136'd0);
    check_output({tag, "_crc_ok"}, 136'(crc_ok_o), 136'd0);
    check_output({tag, "_idx_ok"}, 136'(index_ok_o), 136'd0);
    check_output({tag, "_finish"}, 136'(finish_o), 136'd0);
  endtask

  task automatic apply_stimulus(input logic [39:0] cmd, input logic [1:0] setting);
    @(negedge sd_clk);
    start_i   = 1'b1;
    cmd_i     = cmd;
    setting_i = setting;
    @(posedge sd_clk);
    #1 start_i = 1'b0;
  endtask

  // Collects the 48 transmitted bits; optionally pulses a bogus start_i mid-frame.
  task automatic capture_tx(output logic [47:0] tx, output logic oe_hi, input int inject_at);
    logic [47:0] t;
    t     = 48'd0;
    oe_hi = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge sd_clk);
      t = {t[46:0], cmd_out_o};
      if (cmd_oe_o !== 1'b1) oe_hi = 1'b0;
      if (i == inject_at) begin
        start_i   = 1'b1;
        cmd_i     = 40'h7F_FFFF_FFFF;
        setting_i = 2'b11;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    tx      = t;
  endtask

  task automatic wait_finish(input int max_cycles, output int cycles);
    cycles = -1;
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge sd_clk);
      if (finish_o === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic drive_reply(input logic [135:0] frame, input int nbits, input int nsend);
    for (int j = 0; j < nsend; j++) begin
      cmd_dat_i = frame[nbits - 1 - j];
      @(negedge sd_clk);
    end
    cmd_dat_i = 1'b1;
  endtask

  task automatic run_noresp(input logic [39:0] cmd, input logic [47:0] exp_tx, input int inject_at);
    logic [47:0] tx;
    logic        oe_hi;
    int          c;
    apply_stimulus(cmd, 2'b00);
    capture_tx(tx, oe_hi, inject_at);
    check_output("tx", 136'(tx), 136'(exp_tx));
    check_output("oe_high", 136'(oe_hi), 136'(1'b1));
    wait_finish(100, c);
    check_output("finish_lat", 136'(c), 136'(48 + NCC + 1 - 47));
    @(negedge sd_clk);
    check_output("finish_pulse", 136'(finish_o), 136'd0);
  endtask

  task automatic run_response(input logic [39:0] cmd, input logic [1:0] setting,
                              input logic [47:0] exp_tx, input logic [135:0] frame,
                              input logic [119:0] exp_resp, input logic exp_crc,
                              input logic exp_idx);
    logic [47:0] tx;
    logic        oe_hi;
    int          c;
    int          nbits;
    nbits = setting[1] ? 136 : 48;
    apply_stimulus(cmd, setting);
    capture_tx(tx, oe_hi, -1);
    check_output("tx", 136'(tx), 136'(exp_tx));
    @(negedge sd_clk);
    check_output("oe_released", 136'(cmd_oe_o), 136'd0);
    repeat (4) @(negedge sd_clk);
    drive_reply(frame, nbits, nbits);
    wait_finish(100, c);
    check_output("finish_lat", 136'(c), 136'(NCC + 1));
    check_output("resp", 136'(response_o), 136'(exp_resp));
    check_output("crc_ok", 136'(crc_ok_o), 136'(exp_crc));
    check_output("idx_ok", 136'(index_ok_o), 136'(exp_idx));
    @(negedge sd_clk);
    check_output("finish_pulse", 136'(finish_o), 136'd0);
    check_output("resp_hold", 136'(response_o), 136'(exp_resp));
  endtask

  logic [39:0]  rcmd;
  logic [5:0]   ridx;
  logic [5:0]   reply_idx;
  logic [31:0]  rstatus;
  logic [119:0] rcid;
  logic         rflip;
  logic [47:0]  tx_cap;
  logic         oe_cap;
  int           cyc;
  int           sel;

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    go_idle_i = 1'b0;
    setting_i = 2'b00;
    cmd_i     = 40'd0;
    cmd_dat_i = 1'b1;
    #12;
    check_reset_values("reset");
    @(negedge sd_clk);
    rst = 1'b0;

    // CMD0, no response
    test_no = 1;
    run_noresp(40'h40_0000_0000, 48'h40_0000_0000_95, -1);

    // CMD17 with R1 reply
    test_no = 2;
    run_response(40'h51_0000_0000, 2'b01, 48'h51_0000_0000_55,
                 short_frame(6'd17, 32'h0000_0900, 1'b0),
                 {32'h0000_0900, 88'd0}, 1'b1, 1'b1);

    // CMD2 with R2 reply carrying a CID
    test_no = 3;
    rcid = 120'h15_0100_4D4D_4331_3647_10A5_B2C3_D4E5;
    run_response(40'h42_0000_0000, 2'b11, tx_model(40'h42_0000_0000),
                 long_frame(rcid, 1'b0), rcid, 1'b1, 1'b1);

    // Bad CRC and wrong index
    test_no = 4;
    rstatus = $urandom;
    run_response(40'h51_0000_0000, 2'b01, 48'h51_0000_0000_55,
                 short_frame(6'd18, rstatus, 1'b1),
                 {rstatus, 88'd0}, 1'b0, 1'b0);

    // Abort while waiting for a response, then a normal frame
    test_no = 5;
    apply_stimulus(40'h51_0000_0000, 2'b01);
    capture_tx(tx_cap, oe_cap, -1);
    check_output("tx", 136'(tx_cap), 136'(48'h51_0000_0000_55));
    @(negedge sd_clk);
    check_output("oe_released", 136'(cmd_oe_o), 136'd0);
    repeat (3) @(negedge sd_clk);
    go_idle_i = 1'b1;
    @(negedge sd_clk);
    go_idle_i = 1'b0;
    check_output("abort_oe", 136'(cmd_oe_o), 136'(1'b1));
    check_output("abort_out", 136'(cmd_out_o), 136'(1'b1));
    check_output("abort_crc_ok", 136'(crc_ok_o), 136'd0);
    check_output("abort_idx_ok", 136'(index_ok_o), 136'd0);
    wait_finish(80, cyc);
    check_output("abort_no_finish", 136'(cyc), 136'(-1));
    run_noresp(40'h40_0000_0000, 48'h40_0000_0000_95, -1);

    // start_i pulsed mid-WRITE is ignored
    test_no = 6;
    run_noresp(40'h40_0000_0000, 48'h40_0000_0000_95, 20);

    // rst mid-READ
    test_no = 7;
    apply_stimulus(40'h51_0000_0000, 2'b01);
    capture_tx(tx_cap, oe_cap, -1);
    @(negedge sd_clk);
    repeat (4) @(negedge sd_clk);
    drive_reply(short_frame(6'd17, 32'hFFFF_FFFF, 1'b0), 48, 30);
    check_output("pre_rst_resp_busy", 136'(response_o != 120'd0), 136'(1'b1));
    rst = 1'b1;
    #1;
    check_reset_values("mid_read_rst");
    @(negedge sd_clk);
    rst = 1'b0;
    run_noresp(40'h40_0000_0000, 48'h40_0000_0000_95, -1);

    // Randomised commands against the model
    for (int n = 0; n < 8; n++) begin
      test_no = 10 + n;
      ridx    = 6'($urandom_range(0, 63));
      rcmd    = {2'b01, ridx, 32'($urandom)};
      sel     = $urandom_range(0, 2);
      rflip   = ($urandom_range(0, 3) == 0);
      if (sel == 0) begin
        run_noresp(rcmd, tx_model(rcmd), -1);
      end else if (sel == 1) begin
        rstatus   = $urandom;
        reply_idx = ($urandom_range(0, 3) == 0) ? (ridx ^ 6'($urandom_range(1, 63))) : ridx;
        run_response(rcmd, 2'b01, tx_model(rcmd), short_frame(reply_idx, rstatus, rflip),
                     {rstatus, 88'd0}, !rflip, reply_idx == ridx);
      end else begin
        rcid = {24'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        run_response(rcmd, 2'b11, tx_model(rcmd), long_frame(rcid, rflip),
                     rcid, !rflip, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
